// File: rtl/network_pkg.sv
// Shared packet-header and rule definitions for the classification datapath.
package network_pkg;

    localparam int PROTOCOL_SIZE = 8;
    localparam int IP_SIZE       = 32;
    localparam int PORT_SIZE     = 16;

    typedef struct packed {
        logic [PROTOCOL_SIZE-1:0] protocol;
        logic [IP_SIZE-1:0]       src_ip;
        logic [PORT_SIZE-1:0]     src_port;
        logic [IP_SIZE-1:0]       dst_ip;
        logic [PORT_SIZE-1:0]     dst_port;
    } packet_s;

    // Each field of a rule spans [start, last) or [start, last] depending on the engine.
    typedef struct packed {
        packet_s start;
        packet_s last;
    } rule_s;

endpackage

// File: rtl/rule_match_engine_field_range_check.sv
// Unsigned range test of one header field against one rule bound pair.
module field_range_check #(
    parameter int LENGTH         = 16,
    parameter bit LAST_INCLUSIVE = 1'b0
) (
    input  logic [LENGTH-1:0] value,
    input  logic [LENGTH-1:0] first,
    input  logic [LENGTH-1:0] last,
    output logic              match
);

    logic above_first;
    logic below_last;

    assign above_first = (value >= first);

    // A reversed range (first > last) fails one of the two tests automatically.
    generate
        if (LAST_INCLUSIVE) begin : g_inclusive
            assign below_last = (value <= last);
        end else begin : g_exclusive
            assign below_last = (value < last);
        end
    endgenerate

    assign match = above_first && below_last;

endmodule

// File: rtl/rule_match_engine.sv
// Two-stage 5-tuple classifier: S1 holds the packet and compares it against every
// valid rule; S2 holds the lowest-index hit until downstream accepts it.
module rule_match_engine
    import network_pkg::*;
#(
    parameter int NUM_RULES      = 16,
    parameter int IDX_W          = $clog2(NUM_RULES),
    parameter bit LAST_INCLUSIVE = 1'b0,
    parameter int COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  rule_s              cfg_rule,
    input  logic               cfg_clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  packet_s            in_packet,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_idx,
    input  logic               cnt_clear,
    output logic [COUNT_W-1:0] lookup_count,
    output logic [COUNT_W-1:0] hit_count
);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } lookup_result_s;

    rule_s                rule_table [NUM_RULES];
    logic [NUM_RULES-1:0] rule_valid_reg;
    logic                 cfg_in_range;

    packet_s              s1_packet_reg;
    logic                 s1_valid_reg;
    lookup_result_s       s2_result_reg;
    logic                 s2_valid_reg;
    logic                 s2_load;

    logic [NUM_RULES-1:0] rule_hit;
    lookup_result_s       lookup_next;
    logic                 delivered;
    logic [COUNT_W-1:0]   lookup_count_reg;
    logic [COUNT_W-1:0]   hit_count_reg;

    generate
        if ((1 << IDX_W) > NUM_RULES) begin : g_idx_check
            assign cfg_in_range = (int'(cfg_idx) < NUM_RULES);
        end else begin : g_idx_full
            assign cfg_in_range = 1'b1;
        end
    endgenerate

    // Rule contents carry no reset; only the valid bits gate matching.
    always_ff @(posedge clk) begin
        if (cfg_we && !cfg_clear && cfg_in_range) begin
            rule_table[cfg_idx] <= cfg_rule;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rule_valid_reg <= '0;
        end else if (cfg_clear) begin
            rule_valid_reg <= '0;
        end else if (cfg_we && cfg_in_range) begin
            rule_valid_reg[cfg_idx] <= 1'b1;
        end
    end

    assign s2_load  = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_packet_reg <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_packet_reg <= in_packet;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
        logic [4:0] field_ok;

        field_range_check #(.LENGTH(PROTOCOL_SIZE), .LAST_INCLUSIVE(LAST_INCLUSIVE)) u_protocol (
            .value (s1_packet_reg.protocol),
            .first (rule_table[gi].start.protocol),
            .last  (rule_table[gi].last.protocol),
            .match (field_ok[0])
        );
        field_range_check #(.LENGTH(IP_SIZE), .LAST_INCLUSIVE(LAST_INCLUSIVE)) u_src_ip (
            .value (s1_packet_reg.src_ip),
            .first (rule_table[gi].start.src_ip),
            .last  (rule_table[gi].last.src_ip),
            .match (field_ok[1])
        );
        field_range_check #(.LENGTH(PORT_SIZE), .LAST_INCLUSIVE(LAST_INCLUSIVE)) u_src_port (
            .value (s1_packet_reg.src_port),
            .first (rule_table[gi].start.src_port),
            .last  (rule_table[gi].last.src_port),
            .match (field_ok[2])
        );
        field_range_check #(.LENGTH(IP_SIZE), .LAST_INCLUSIVE(LAST_INCLUSIVE)) u_dst_ip (
            .value (s1_packet_reg.dst_ip),
            .first (rule_table[gi].start.dst_ip),
            .last  (rule_table[gi].last.dst_ip),
            .match (field_ok[3])
        );
        field_range_check #(.LENGTH(PORT_SIZE), .LAST_INCLUSIVE(LAST_INCLUSIVE)) u_dst_port (
            .value (s1_packet_reg.dst_port),
            .first (rule_table[gi].start.dst_port),
            .last  (rule_table[gi].last.dst_port),
            .match (field_ok[4])
        );

        assign rule_hit[gi] = rule_valid_reg[gi] && (&field_ok);
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        lookup_next = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (rule_hit[i]) begin
                lookup_next.hit = 1'b1;
                lookup_next.idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= lookup_next;
            end
        end
    end

    assign delivered = s2_valid_reg && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_count_reg <= '0;
            hit_count_reg    <= '0;
        end else if (cnt_clear) begin
            lookup_count_reg <= '0;
            hit_count_reg    <= '0;
        end else if (delivered) begin
            if (lookup_count_reg != {COUNT_W{1'b1}}) begin
                lookup_count_reg <= lookup_count_reg + 1'b1;
            end
            if (s2_result_reg.hit && (hit_count_reg != {COUNT_W{1'b1}})) begin
                hit_count_reg <= hit_count_reg + 1'b1;
            end
        end
    end

    assign out_valid    = s2_valid_reg;
    assign out_hit      = s2_result_reg.hit;
    assign out_idx      = s2_result_reg.idx;
    assign lookup_count = lookup_count_reg;
    assign hit_count    = hit_count_reg;

endmodule

// File: tb/tb_rule_match_engine.sv
// Scoreboard bench: two engines (exclusive and inclusive upper bounds) share one
// stimulus stream and are checked against a behavioural rule-table model.
`timescale 1ns/1ps
module tb_rule_match_engine;
    import network_pkg::*;

    localparam int NUM_RULES = 12;
    localparam int IDX_W     = 4;
    localparam int COUNT_W   = 6;
    localparam longint CNT_MAX = (1 << COUNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    rule_s cfg_rule = '0;
    logic cfg_clear = 1'b0;
    logic in_valid = 1'b0;
    packet_s in_packet = '0;
    logic out_ready = 1'b0;
    logic cnt_clear = 1'b0;

    logic [1:0] in_ready, out_valid, out_hit;
    logic [1:0][IDX_W-1:0] out_idx;
    logic [1:0][COUNT_W-1:0] lookup_count, hit_count;

    rule_match_engine #(.NUM_RULES(NUM_RULES), .IDX_W(IDX_W), .LAST_INCLUSIVE(1'b0), .COUNT_W(COUNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule(cfg_rule),
        .cfg_clear(cfg_clear), .in_valid(in_valid), .in_ready(in_ready[0]), .in_packet(in_packet),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_hit(out_hit[0]), .out_idx(out_idx[0]),
        .cnt_clear(cnt_clear), .lookup_count(lookup_count[0]), .hit_count(hit_count[0]));

    rule_match_engine #(.NUM_RULES(NUM_RULES), .IDX_W(IDX_W), .LAST_INCLUSIVE(1'b1), .COUNT_W(COUNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule(cfg_rule),
        .cfg_clear(cfg_clear), .in_valid(in_valid), .in_ready(in_ready[1]), .in_packet(in_packet),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_hit(out_hit[1]), .out_idx(out_idx[1]),
        .cnt_clear(cnt_clear), .lookup_count(lookup_count[1]), .hit_count(hit_count[1]));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    rule_s  m_rule [NUM_RULES];
    bit     m_valid [NUM_RULES];
    int     exp_q [$];
    int     accepted = 0;
    int     delivered = 0;
    longint m_lookups = 0;
    longint m_hits [2] = '{0, 0};
    int     ready_mode = 0;
    packet_s pkt_p;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit in_range(input longint v, input longint f, input longint l, input bit incl);
        return (v >= f) && (incl ? (v <= l) : (v < l));
    endfunction

    // Result code: bit 4 = hit, bits 3:0 = index of the lowest matching rule.
    function automatic int model_lookup(input packet_s p, input bit incl);
        for (int i = 0; i < NUM_RULES; i++) begin
            if (m_valid[i]
                && in_range(p.protocol, m_rule[i].start.protocol, m_rule[i].last.protocol, incl)
                && in_range(p.src_ip,   m_rule[i].start.src_ip,   m_rule[i].last.src_ip,   incl)
                && in_range(p.src_port, m_rule[i].start.src_port, m_rule[i].last.src_port, incl)
                && in_range(p.dst_ip,   m_rule[i].start.dst_ip,   m_rule[i].last.dst_ip,   incl)
                && in_range(p.dst_port, m_rule[i].start.dst_port, m_rule[i].last.dst_port, incl))
                return 16 | i;
        end
        return 0;
    endfunction

    function automatic packet_s mkpkt(input int pr, input int sip, input int sp, input int dip, input int dp);
        packet_s p;
        p.protocol = PROTOCOL_SIZE'(pr);
        p.src_ip   = IP_SIZE'(sip);
        p.src_port = PORT_SIZE'(sp);
        p.dst_ip   = IP_SIZE'(dip);
        p.dst_port = PORT_SIZE'(dp);
        return p;
    endfunction

    function automatic rule_s point_rule(input packet_s p);
        rule_s r;
        r.start = p;
        r.last  = mkpkt(int'(p.protocol) + 1, int'(p.src_ip) + 1, int'(p.src_port) + 1,
                        int'(p.dst_ip) + 1, int'(p.dst_port) + 1);
        return r;
    endfunction

    function automatic int rnd_last(input int s);
        return s + $urandom_range(0, 8) - 1;
    endfunction

    function automatic rule_s rand_rule();
        rule_s r;
        int a, b, c, d, e;
        a = $urandom_range(1, 20); b = $urandom_range(1, 20); c = $urandom_range(1, 20);
        d = $urandom_range(1, 20); e = $urandom_range(1, 20);
        r.start = mkpkt(a, b, c, d, e);
        r.last  = mkpkt(rnd_last(a), rnd_last(b), rnd_last(c), rnd_last(d), rnd_last(e));
        return r;
    endfunction

    function automatic int near(input longint s);
        return int'(s) + $urandom_range(0, 9) - 1;
    endfunction

    function automatic packet_s rand_pkt();
        rule_s r;
        r = m_rule[$urandom_range(0, NUM_RULES - 1)];
        return mkpkt(near(r.start.protocol), near(r.start.src_ip), near(r.start.src_port),
                     near(r.start.dst_ip), near(r.start.dst_port));
    endfunction

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic cfg(input bit we, input int idx, input rule_s r, input bit clr);
        cfg_we = we; cfg_idx = IDX_W'(idx); cfg_rule = r; cfg_clear = clr;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_clear = 1'b0;
        if (clr) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (we && idx < NUM_RULES) begin
            m_rule[idx] = r;
            m_valid[idx] = 1'b1;
        end
    endtask

    task automatic send(input packet_s p);
        int t = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_packet = p;
        while (!done) begin
            @(negedge clk);
            done = in_ready[0];
            @(posedge clk); #1;
            if (!done && ++t > 200) begin
                check("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (delivered != accepted && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_complete", delivered, accepted);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) out_ready = 1'b0;
        end
    end

    // Input side: ready is expected whenever fewer than two results are pending or
    // the output is being drained; each accepted packet pushes its expected results.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready0", in_ready[0], ((accepted - delivered) < 2) || out_ready);
                check("in_ready1", in_ready[1], ((accepted - delivered) < 2) || out_ready);
                if (in_valid && in_ready[0]) begin
                    exp_q.push_back(model_lookup(in_packet, 1'b0) | (model_lookup(in_packet, 1'b1) << 8));
                    accepted++;
                end
            end
        end
    end

    initial begin
        bit hold = 1'b0;
        logic [1:0] hold_hit;
        logic [1:0][IDX_W-1:0] hold_idx;
        int e;
        forever begin
            @(negedge clk); #1;
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    check("lookup_count", lookup_count[k], m_lookups);
                    check("hit_count", hit_count[k], m_hits[k]);
                    if (hold) begin
                        check("hold_valid", out_valid[k], 1);
                        check("hold_hit", out_hit[k], hold_hit[k]);
                        check("hold_idx", out_idx[k], hold_idx[k]);
                    end
                end
                e = -1;
                if (out_valid[0] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        delivered++;
                        check("out_valid1", out_valid[1], 1);
                        check("out_hit0", out_hit[0], (e >> 4) & 1);
                        check("out_idx0", out_idx[0], e & 15);
                        check("out_hit1", out_hit[1], (e >> 12) & 1);
                        check("out_idx1", out_idx[1], (e >> 8) & 15);
                        $display("result %0d: excl hit=%0d idx=%0d | incl hit=%0d idx=%0d",
                                 delivered, out_hit[0], out_idx[0], out_hit[1], out_idx[1]);
                    end
                end
                hold = out_valid[0] && !out_ready;
                hold_hit = out_hit;
                hold_idx = out_idx;
                if (cnt_clear) begin
                    m_lookups = 0; m_hits[0] = 0; m_hits[1] = 0;
                end else if (e >= 0) begin
                    if (m_lookups < CNT_MAX) m_lookups++;
                    if (((e >> 4) & 1) == 1 && m_hits[0] < CNT_MAX) m_hits[0]++;
                    if (((e >> 12) & 1) == 1 && m_hits[1] < CNT_MAX) m_hits[1]++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rule_s r;
        pkt_p = mkpkt(6, 100, 1000, 200, 80);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_in_ready", in_ready[k], 1);
            check("reset_out_valid", out_valid[k], 0);
            check("reset_out_hit", out_hit[k], 0);
            check("reset_out_idx", out_idx[k], 0);
            check("reset_lookup_count", lookup_count[k], 0);
            check("reset_hit_count", hit_count[k], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single rule in slot 3, latency and first counter values.
        cfg(1'b1, 3, point_rule(pkt_p), 1'b0);
        send(pkt_p);
        @(negedge clk);
        check("latency_early", out_valid[0], 0);
        @(negedge clk);
        check("latency_valid", out_valid[0], 1);
        @(posedge clk); #1;
        drain();
        check("first_lookup_count", lookup_count[0], 1);
        check("first_hit_count", hit_count[0], 1);

        // Priority between slots 2 and 5, then slot 2 stops covering P.
        cfg(1'b0, 0, '0, 1'b1);
        cfg(1'b1, 5, point_rule(pkt_p), 1'b0);
        cfg(1'b1, 2, point_rule(pkt_p), 1'b0);
        send(pkt_p);
        cfg(1'b1, 2, point_rule(mkpkt(6, 100, 1000, 200, 85)), 1'b0);
        send(pkt_p);
        drain();

        // Destination-port boundaries of [80,443).
        cfg(1'b0, 0, '0, 1'b1);
        r.start = mkpkt(0, 0, 0, 0, 80);
        r.last  = mkpkt(200, 1000, 1000, 1000, 443);
        cfg(1'b1, 0, r, 1'b0);
        foreach (r.start.dst_port[i]) ; // no-op keeps r in scope
        send(mkpkt(10, 10, 10, 10, 79));
        send(mkpkt(10, 10, 10, 10, 80));
        send(mkpkt(10, 10, 10, 10, 442));
        send(mkpkt(10, 10, 10, 10, 443));
        drain();

        // Backpressure: three packets while the output is stalled for four cycles.
        cfg(1'b1, 4, point_rule(pkt_p), 1'b0);
        @(negedge clk);
        ready_mode = 2;
        @(posedge clk); #1;
        fork
            begin
                send(pkt_p);
                send(mkpkt(10, 10, 10, 10, 100));
                send(mkpkt(10, 10, 10, 10, 500));
            end
            begin
                repeat (4) @(negedge clk);
                ready_mode = 0;
            end
        join
        drain();

        // Clear wins over a same-cycle write; an out-of-range slot write is ignored.
        cfg(1'b1, 0, point_rule(pkt_p), 1'b1);
        send(pkt_p);
        cfg(1'b1, NUM_RULES, point_rule(pkt_p), 1'b0);
        send(pkt_p);
        drain();

        // Randomised rounds; counters saturate during the later rounds.
        for (int round = 0; round < 8; round++) begin
            drain();
            ready_mode = 0;
            if ($urandom_range(0, 2) == 0) cfg(1'b0, 0, '0, 1'b1);
            repeat (10) cfg(1'b1, $urandom_range(0, 15), rand_rule(), 1'b0);
            ready_mode = 1;
            for (int n = 0; n < 40; n++) begin
                send(rand_pkt());
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                if (round < 4 && $urandom_range(0, 30) == 0) begin
                    cnt_clear = 1'b1;
                    @(posedge clk); #1;
                    cnt_clear = 1'b0;
                end
            end
        end
        ready_mode = 0;
        drain();
        check("lookup_saturated", lookup_count[0], CNT_MAX);

        // Counter clear coinciding with a delivery.
        @(negedge clk);
        ready_mode = 3;
        out_ready = 1'b0;
        @(posedge clk); #1;
        send(pkt_p);
        @(posedge clk); #1;
        check("held_result_valid", out_valid[0], 1);
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        check("clear_lookup_count", lookup_count[0], 0);
        check("clear_hit_count", hit_count[0], 0);
        check("clear_hit_count_incl", hit_count[1], 0);
        ready_mode = 0;
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rule_match_engine.md
# rule_match_engine

Parametrised, pipelined packet classifier that replaces single-rule matching with an on-chip table of NUM_RULES 5-tuple range rules. Each accepted packet is checked against every valid rule in parallel, and the lowest-index hit is reported. Packets arrive and leave over valid/ready handshakes. The block sits between the packet parser and the action/forwarding stage, and also keeps saturating lookup and hit counters.

## Interface
Parameters:
- NUM_RULES, 16, rule table depth (≥2)
- IDX_W, $clog2(NUM_RULES), rule index width
- LAST_INCLUSIVE, 0, 0: a field matches when first ≤ value < last; 1: when first ≤ value ≤ last
- COUNT_W, 32, width of the statistics counters

Ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write cfg_rule into slot cfg_idx and set that slot valid
- cfg_idx  in  IDX_W  slot to write
- cfg_rule  in  rule_s  rule bounds (start/last packet_s)
- cfg_clear  in  1  invalidate all slots
- in_valid  in  1  packet present
- in_ready  out  1  block accepts the packet
- in_packet  in  packet_s  packet header fields
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_hit  out  1  at least one valid rule matched
- out_idx  out  IDX_W  lowest matching index; 0 when out_hit=0
- cnt_clear  in  1  synchronous clear of both counters
- lookup_count  out  COUNT_W  results delivered
- hit_count  out  COUNT_W  delivered results with out_hit=1

## Operation
- Table: NUM_RULES × rule_s, plus a valid bit per slot. Reset clears every valid bit. Rule contents are not reset.
- cfg_we with cfg_idx ≥ NUM_RULES: ignored.
- cfg_clear and cfg_we in the same cycle: clear wins and the write is dropped.
- Rule match: a rule matches when its slot is valid and all five fields (protocol, src ip, src port, dst ip, dst port) are in range. Fields are compared as unsigned values at their package widths.
- Degenerate rule with first==last: never matches when LAST_INCLUSIVE=0. Matches only value==first when LAST_INCLUSIVE=1. first>last never matches.
- Priority: the lowest index among matching rules wins.
- Pipeline:
  - S1: packet register and s1_valid.
  - In S1, compare against all rules and priority-encode.
  - S2: out_hit, out_idx and out_valid registers.
- Counters saturate at all-ones and increment on each out_valid && out_ready. cnt_clear wins over an increment in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_hit=0, out_idx=0, both counters 0, s1_valid=0.
- s2_load = !out_valid || out_ready.
- S1 advances when s2_load is true.
- in_ready = !s1_valid || s2_load. Combinational from out_ready, no other dependence.
- Latency: a packet accepted at edge k produces out_valid=1 after edge k+1, when there is no backpressure. Throughput is 1 packet per cycle.
- Table snapshot: the result reflects table state during the cycle S1 transfers into S2. A config write committed at edge e is visible to a transfer at edge e+1 or later. A stalled packet in S1 sees writes made while it waits.
- Output stability: while out_valid && !out_ready, out_hit and out_idx hold steady.
- Asserting rst_n low mid-stream discards in-flight packets immediately. No result is emitted for them.

## Structure
- network_pkg (existing) supplies rule_s, packet_s, PROTOCOL_SIZE, IP_SIZE and PORT_SIZE. Add a lookup_result_s (hit, idx) parametrised through the module.
- Sub-module field_range_check, parameterised by LENGTH and LAST_INCLUSIVE. Instantiate 5 per rule via generate.
- Priority encoder: a for-loop in always_comb inside rule_match_engine.

## Test plan
- Reset, then write slot 3 with a range containing packet P; send P → out_valid 2 edges after acceptance, out_hit=1, out_idx=3, lookup_count=1, hit_count=1.
- Slots 2 and 5 both match P → out_idx=2. Clear slot-2 coverage by writing a non-matching rule to slot 2 → next P gives out_idx=5.
- Boundaries, LAST_INCLUSIVE=0, dst port range [80,443): port 79 misses, 80 hits, 442 hits, 443 misses. Rerun with LAST_INCLUSIVE=1: 443 hits.
- out_ready held low for 4 cycles while streaming 3 packets: in_ready drops after 2 are buffered, outputs stay stable, all 3 results arrive in order, none lost or duplicated.
- cfg_clear and cfg_we to slot 0 in the same cycle → the next lookup misses (out_hit=0, out_idx=0). Also, cfg_idx=NUM_RULES is ignored.
- Preload lookup_count to all-ones − 1 via forced stimulus, deliver 3 results → it saturates at all-ones. Then cnt_clear together with a delivery → both counters read 0.
